stream_distributor: RTL and testbench

Parametrised, registered 1-to-N stream distributor with valid/ready handshakes and a FIFO on every output channel. Each accepted input beat is routed to one channel, chosen either by an explicit select field or by a round-robin pointer, and buffered until that channel's consumer takes it. The block replaces the purely combinational distributor wherever downstream consumers can stall. It sits between a single producer and up to `CHANNELS` independent consumers.

---
 rtl/stream_distributor_if.sv | 32 +++
 rtl/stream_distributor.sv | 114 +++++++++++
 tb/tb_stream_distributor.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/stream_distributor_if.sv
// stream_distributor_if: producer/consumer handshake bundle for stream_distributor.
// Handshake rule: a beat moves on a channel at a rising edge exactly when that
// channel's valid and ready are both high; valid never waits on ready.
// The master modport is the environment (producer and consumers). The slave
// modport is the distributor itself.
interface stream_distributor_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic                      enable;
  logic                      in_valid;
  logic                      in_ready;
  logic [SEL_W-1:0]          in_sel;
  logic [WIDTH-1:0]          in_data;
  logic                      rr_mode;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic                      err_sel;

  modport master (
    output enable, in_valid, in_sel, in_data, rr_mode, out_ready,
    input  in_ready, out_valid, out_data, err_sel
  );

  modport slave (
    input  enable, in_valid, in_sel, in_data, rr_mode, out_ready,
    output in_ready, out_valid, out_data, err_sel
  );
endinterface

// File: rtl/stream_distributor.sv
// stream_distributor: 1-to-CHANNELS stream distributor with one FIFO per output.
// Each accepted input beat goes to the channel named by in_sel, or by a
// round-robin pointer. The beat waits in that channel's FIFO until the
// consumer takes it.
// Optional feature macro: STREAM_DISTRIBUTOR_RR_EN. When it is defined,
// rr_mode is honoured and the round-robin pointer is built. When it is not
// defined, routing always uses in_sel.
module stream_distributor #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 2
) (
  input logic                 clk,
  input logic                 rst,
  stream_distributor_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SEL_N = 1 << SEL_W;

  logic [SEL_W-1:0]    tgt;
  logic                tgt_ok;
  logic                accept;
  logic [CHANNELS-1:0] full;
  logic [SEL_N-1:0]    full_ext;
  logic                err_q;

`ifdef STREAM_DISTRIBUTOR_RR_EN
  logic [SEL_W-1:0] rr_ptr;

  assign tgt = bus.rr_mode ? rr_ptr : bus.in_sel;

  // Round-robin pointer: step on each beat accepted in round-robin mode, wrapping at CHANNELS-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept && bus.rr_mode) begin
      if (rr_ptr == SEL_W'(CHANNELS - 1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= rr_ptr + SEL_W'(1);
      end
    end
  end
`else
  logic rr_mode_unused;
  assign rr_mode_unused = bus.rr_mode;
  assign tgt            = bus.in_sel;
`endif

  // A select of CHANNELS or higher can only occur when CHANNELS is not a power of two.
  assign tgt_ok = ({1'b0, tgt} < (SEL_W + 1)'(CHANNELS));

  // Pad the full flags out to the whole select range so that any tgt indexes safely.
  always_comb begin
    full_ext                 = '0;
    full_ext[CHANNELS-1:0]   = full;
  end

  // An invalid target is always ready: its beat is taken and dropped.
  assign bus.in_ready = !rst && bus.enable && (!tgt_ok || !full_ext[tgt]);
  assign accept       = bus.in_valid && bus.in_ready;

  // Dropped-beat flag: a one-cycle pulse on the cycle after an invalid-select accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && !tgt_ok;
    end
  end

  assign bus.err_sel = err_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // A full FIFO refuses the push even when it is popped in the same cycle.
    assign push = accept && tgt_ok && (tgt == SEL_W'(i));
    assign pop  = (count != '0) && bus.out_ready[i];

    assign full[i]                         = (count == CNT_W'(DEPTH));
    assign bus.out_valid[i]                = (count != '0);
    assign bus.out_data[i*WIDTH +: WIDTH]  = (count != '0) ? mem[rd_ptr] : '0;

    // Channel FIFO: the pointers wrap modulo DEPTH and the count tracks occupancy.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= bus.in_data;
          wr_ptr      <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (push && !pop) begin
          count <= count + CNT_W'(1);
        end else if (pop && !push) begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_stream_distributor.sv
// tb_stream_distributor: runs two distributors (4 channels and 3 channels, DEPTH 2)
// side by side on the same stimulus. Outputs are compared with a queue-based
// model of the routing and buffering rules. Directed steps come first,
// followed by random traffic.
module tb_stream_distributor;
  localparam int DEPTH = 2;
`ifdef STREAM_DISTRIBUTOR_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  stream_distributor_if #(.WIDTH(8), .CHANNELS(4)) bus4 ();
  stream_distributor_if #(.WIDTH(8), .CHANNELS(3)) bus3 ();

  stream_distributor #(.WIDTH(8), .CHANNELS(4), .DEPTH(DEPTH)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  stream_distributor #(.WIDTH(8), .CHANNELS(3), .DEPTH(DEPTH)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue index is inst*4 + channel
  logic [7:0] mq [8][$];
  int         rr_m  [2];
  logic       err_m [2];

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s inst%0d: got %0h want %0h", tag, k, obs, exp);
    end
  endtask

  // One clock cycle: drive the inputs, check the outputs before the edge, then advance the model.
  task automatic step(input logic r, input logic en, input logic v, input logic [1:0] sel,
                      input logic [7:0] d, input logic rrm, input logic [3:0] ordy);
    int         tgt [2];
    logic       rdy [2];
    logic [3:0] ev;
    logic [31:0] ed;
    logic [3:0] ov;
    logic [31:0] od;
    logic       ordy_b;
    int         nch;
    @(negedge clk);
    rst            = r;
    bus4.enable    = en;  bus3.enable   = en;
    bus4.in_valid  = v;   bus3.in_valid = v;
    bus4.in_sel    = sel; bus3.in_sel   = sel;
    bus4.in_data   = d;   bus3.in_data  = d;
    bus4.rr_mode   = rrm; bus3.rr_mode  = rrm;
    bus4.out_ready = ordy;
    bus3.out_ready = ordy[2:0];
    #1;
    for (int k = 0; k < 2; k++) begin
      nch    = (k == 0) ? 4 : 3;
      tgt[k] = (RR_EN && rrm) ? rr_m[k] : int'(sel);
      rdy[k] = !r && en && (tgt[k] >= nch || mq[k*4 + tgt[k]].size() < DEPTH);
      ev = '0;
      ed = '0;
      for (int c = 0; c < nch; c++) begin
        if (mq[k*4 + c].size() > 0) begin
          ev[c]       = 1'b1;
          ed[c*8 +: 8] = mq[k*4 + c][0];
        end
      end
      if (k == 0) begin
        check("in_ready", k, {31'd0, bus4.in_ready}, {31'd0, rdy[k]});
        check("err_sel", k, {31'd0, bus4.err_sel}, {31'd0, err_m[k]});
        ov = bus4.out_valid;
        od = bus4.out_data;
      end else begin
        check("in_ready", k, {31'd0, bus3.in_ready}, {31'd0, rdy[k]});
        check("err_sel", k, {31'd0, bus3.err_sel}, {31'd0, err_m[k]});
        ov = {1'b0, bus3.out_valid};
        od = {8'd0, bus3.out_data};
      end
      check("out_valid", k, {28'd0, ov}, {28'd0, ev});
      check("out_data", k, od, ed);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      nch = (k == 0) ? 4 : 3;
      if (r) begin
        for (int c = 0; c < 4; c++) mq[k*4 + c].delete();
        rr_m[k]  = 0;
        err_m[k] = 1'b0;
      end else begin
        for (int c = 0; c < nch; c++) begin
          ordy_b = ordy[c];
          if (ordy_b && mq[k*4 + c].size() > 0) void'(mq[k*4 + c].pop_front());
        end
        err_m[k] = v && rdy[k] && (tgt[k] >= nch);
        if (v && rdy[k] && tgt[k] < nch) mq[k*4 + tgt[k]].push_back(d);
        if (v && rdy[k] && RR_EN && rrm) rr_m[k] = (rr_m[k] + 1) % nch;
      end
    end
  endtask

  initial begin
    logic       r_r;
    logic       en_r;
    logic       v_r;
    logic       rrm_r;
    logic [1:0] sel_r;
    logic [7:0] d_r;
    logic [3:0] ordy_r;
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    bus4.enable = 1'b0; bus3.enable = 1'b0;
    bus4.in_valid = 1'b0; bus3.in_valid = 1'b0;
    bus4.in_sel = '0; bus3.in_sel = '0;
    bus4.in_data = '0; bus3.in_data = '0;
    bus4.rr_mode = 1'b0; bus3.rr_mode = 1'b0;
    bus4.out_ready = '0; bus3.out_ready = '0;
    for (int k = 0; k < 2; k++) begin
      rr_m[k]  = 0;
      err_m[k] = 1'b0;
    end
    repeat (2) @(posedge clk);

    // Reset state, then fill channel 2 in address mode with no consumers ready
    step(1, 1, 0, 2'd0, 8'h00, 0, 4'h0);
    step(0, 1, 1, 2'd2, 8'h11, 0, 4'h0);
    step(0, 1, 1, 2'd2, 8'h22, 0, 4'h0);
    step(0, 1, 1, 2'd2, 8'h33, 0, 4'h0);
    // Drain channel 2 in order
    step(0, 1, 0, 2'd2, 8'h44, 0, 4'b0100);
    step(0, 1, 0, 2'd2, 8'h44, 0, 4'b0100);
    step(0, 1, 0, 2'd2, 8'h44, 0, 4'b0100);
    step(0, 1, 0, 2'd2, 8'h44, 0, 4'b0100);

    // Round-robin back to back with all consumers ready
    for (int i = 0; i < 6; i++) step(0, 1, 1, 2'd0, 8'hA0 + 8'(i), 1, 4'hF);
    step(0, 1, 0, 2'd0, 8'h00, 1, 4'hF);

    // Round-robin stall: consumer 1 held off until its FIFO fills
    for (int i = 0; i < 12; i++) step(0, 1, 1, 2'd0, 8'hB0 + 8'(i), 1, 4'b1101);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 2'd0, 8'hC0 + 8'(i), 1, 4'hF);
    step(0, 1, 0, 2'd0, 8'h00, 1, 4'hF);
    step(0, 1, 0, 2'd0, 8'h00, 1, 4'hF);

    // Select 3: an invalid channel for the 3-channel instance
    step(0, 1, 1, 2'd3, 8'h5A, 0, 4'h0);
    step(0, 1, 0, 2'd3, 8'h00, 0, 4'h0);
    step(0, 1, 0, 2'd3, 8'h00, 0, 4'h0);

    // Disable input while draining
    step(0, 1, 1, 2'd0, 8'h61, 0, 4'h0);
    step(0, 0, 1, 2'd1, 8'h62, 0, 4'hF);
    step(0, 0, 1, 2'd1, 8'h63, 0, 4'hF);
    step(0, 0, 1, 2'd1, 8'h64, 0, 4'hF);

    // Reset while channel 0 holds a beat
    step(0, 1, 1, 2'd0, 8'h71, 0, 4'h0);
    step(1, 1, 0, 2'd0, 8'h00, 0, 4'h0);
    step(0, 1, 0, 2'd0, 8'h00, 0, 4'h0);

    // Random traffic
    rrm_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      r_r    = ($urandom_range(0, 49) == 0);
      en_r   = ($urandom_range(0, 9) != 0);
      v_r    = ($urandom_range(0, 3) != 0);
      sel_r  = 2'($urandom_range(0, 3));
      d_r    = 8'($urandom);
      ordy_r = 4'($urandom);
      if ($urandom_range(0, 15) == 0) rrm_r = ~rrm_r;
      step(r_r, en_r, v_r, sel_r, d_r, rrm_r, ordy_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
